// File: rtl/nios_uart_mem_arbiter.sv
// Round-robin, bounded-hold arbiter sharing one single-port 1024x32 RAM between
// the Nios II data master (port A) and the SERDES capture/playback engine (port B).
// Optional build macro MEM_ARB_WP_EN adds a port-B write-protect window.
module nios_uart_mem_arbiter #(
  parameter int                ADDR_W   = 10,
  parameter int                DATA_W   = 32,
  parameter int                BE_W     = DATA_W / 8,
  parameter int                MAX_HOLD = 8,
  parameter logic [ADDR_W-1:0] WP_BASE  = ADDR_W'(10'h000),
  parameter logic [ADDR_W-1:0] WP_LIMIT = ADDR_W'(10'h0FF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [BE_W-1:0]   a_byteenable,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [DATA_W-1:0] a_writedata,
  output logic              a_waitrequest,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [BE_W-1:0]   b_byteenable,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [DATA_W-1:0] b_writedata,
  output logic              b_waitrequest,
  output logic [DATA_W-1:0] b_readdata,
  output logic              b_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              wp_violation
);

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  port_e      owner, owner_next, rd_port, grant_port;
  logic [7:0] hold_cnt, hold_next;
  logic       rd_pend, wp_flag;
  logic       req_a, req_b, grant_a, grant_b, grant_any;
  logic       gnt_read, gnt_write, wp_hit;

  assign req_a = a_read | a_write;
  assign req_b = b_read | b_write;

  // Under contention the owner wins unless it has used up its hold budget;
  // the XOR flips the winner exactly when the budget is exhausted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      if (req_a && req_b) begin
        if ((owner == PORT_A) ^ (hold_cnt == HOLD_MAX)) grant_a = 1'b1;
        else                                             grant_b = 1'b1;
      end else begin
        grant_a = req_a;
        grant_b = req_b;
      end
    end
  end

  assign grant_any  = grant_a | grant_b;
  assign grant_port = grant_b ? PORT_B : PORT_A;

  // Read+write together on one port is a write with no data return.
  assign gnt_write = (grant_a & a_write) | (grant_b & b_write);
  assign gnt_read  = (grant_a & a_read & ~a_write) | (grant_b & b_read & ~b_write);

`ifdef MEM_ARB_WP_EN
  // Window test as one unsigned offset compare; relies on WP_BASE <= WP_LIMIT.
  localparam logic [ADDR_W-1:0] WP_SPAN = WP_LIMIT - WP_BASE;
  logic [ADDR_W-1:0] b_offset;
  assign b_offset = b_address - WP_BASE;
  assign wp_hit   = grant_b & b_write & (b_offset <= WP_SPAN);
`else
  logic unused_wp_window;
  assign unused_wp_window = ^{WP_BASE, WP_LIMIT};
  assign wp_hit           = 1'b0;
`endif

  assign mem_address    = grant_b ? b_address    : a_address;
  assign mem_byteenable = grant_b ? b_byteenable : a_byteenable;
  assign mem_writedata  = grant_b ? b_writedata  : a_writedata;
  assign mem_chipselect = grant_any & ~wp_hit;
  assign mem_write      = gnt_write & ~wp_hit;

  assign a_waitrequest = reset | (req_a & ~grant_a);
  assign b_waitrequest = reset | (req_b & ~grant_b);

  // The RAM output is unregistered, so both ports see it; only the strobe is steered.
  assign a_readdata      = mem_readdata;
  assign b_readdata      = mem_readdata;
  assign a_readdatavalid = ~reset & rd_pend & (rd_port == PORT_A);
  assign b_readdatavalid = ~reset & rd_pend & (rd_port == PORT_B);
  assign wp_violation    = wp_flag;

  always_comb begin
    owner_next = owner;
    hold_next  = hold_cnt;
    if (grant_any) begin
      if (grant_port == owner) begin
        if (hold_cnt < HOLD_MAX) hold_next = hold_cnt + 8'd1;
      end else begin
        owner_next = grant_port;
        hold_next  = 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      owner    <= PORT_A;
      hold_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_port  <= PORT_A;
      wp_flag  <= 1'b0;
    end else begin
      owner    <= owner_next;
      hold_cnt <= hold_next;
      rd_pend  <= gnt_read;
      rd_port  <= grant_port;
      if (wp_hit) wp_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nios_uart_mem_arbiter.sv
// Self-checking bench for nios_uart_mem_arbiter: directed scenarios plus a randomized
// two-master run against a transaction-level model and a behavioural 1024x32 RAM.
module tb_nios_uart_mem_arbiter;

  localparam int MAX_HOLD   = 8;
  localparam int WP_BASE_I  = 'h000;
  localparam int WP_LIMIT_I = 'h0FF;
`ifdef MEM_ARB_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  typedef struct {
    bit        valid;
    bit        rd;
    bit        wr;
    bit [9:0]  addr;
    bit [31:0] data;
    bit [3:0]  be;
  } req_t;

  logic        clk, reset;
  logic [9:0]  a_address, b_address, mem_address;
  logic [3:0]  a_byteenable, b_byteenable, mem_byteenable;
  logic        a_read, a_write, b_read, b_write;
  logic [31:0] a_writedata, b_writedata, a_readdata, b_readdata;
  logic        a_waitrequest, b_waitrequest, a_readdatavalid, b_readdatavalid;
  logic        mem_chipselect, mem_write, wp_violation;
  logic [31:0] mem_writedata, mem_readdata;

  int checks = 0;
  int errors = 0;

  bit [31:0] mem_arr [1024];
  bit [31:0] ref_mem [1024];
  bit [9:0]  mem_addr_q;
  int        m_owner, m_hold;

  nios_uart_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .a_address(a_address), .a_byteenable(a_byteenable), .a_read(a_read), .a_write(a_write),
    .a_writedata(a_writedata), .a_waitrequest(a_waitrequest), .a_readdata(a_readdata),
    .a_readdatavalid(a_readdatavalid),
    .b_address(b_address), .b_byteenable(b_byteenable), .b_read(b_read), .b_write(b_write),
    .b_writedata(b_writedata), .b_waitrequest(b_waitrequest), .b_readdata(b_readdata),
    .b_readdatavalid(b_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .wp_violation(wp_violation)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: registered address, unregistered read output.
  always @(posedge clk) begin
    if (mem_chipselect) begin
      mem_addr_q <= mem_address;
      if (mem_write)
        for (int i = 0; i < 4; i++)
          if (mem_byteenable[i]) mem_arr[mem_address][8*i +: 8] <= mem_writedata[8*i +: 8];
    end
  end
  assign mem_readdata = mem_arr[mem_addr_q];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    a_address = '0; a_byteenable = '0; a_read = 0; a_write = 0; a_writedata = '0;
    b_address = '0; b_byteenable = '0; b_read = 0; b_write = 0; b_writedata = '0;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    drive_idle();
    repeat (n) tick();
    reset = 1'b0;
    m_owner = 0;
    m_hold  = 0;
  endtask

  function automatic bit [31:0] merge(bit [31:0] old_w, bit [31:0] new_w, bit [3:0] be);
    merge = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) merge[8*i +: 8] = new_w[8*i +: 8];
  endfunction

  function automatic bit wp_blocks(int port, bit wr, bit [9:0] addr);
    return WP_ON && port == 1 && wr && int'(addr) >= WP_BASE_I && int'(addr) <= WP_LIMIT_I;
  endfunction

  // Arbitration rule: lone requester wins; under contention the last winner keeps
  // going until it has MAX_HOLD grants in a row.
  function automatic int pick(bit ra, bit rb);
    if (ra && rb) return (m_hold == MAX_HOLD) ? 1 - m_owner : m_owner;
    if (ra) return 0;
    if (rb) return 1;
    return -1;
  endfunction

  task automatic note_grant(input int w);
    if (w >= 0) begin
      if (w == m_owner) begin
        if (m_hold < MAX_HOLD) m_hold++;
      end else begin
        m_owner = w;
        m_hold  = 1;
      end
    end
  endtask

  function automatic req_t new_req();
    req_t r;
    int   kind;
    kind    = $urandom_range(9);
    r.valid = 1'b1;
    r.rd    = (kind < 4) || (kind == 9);
    r.wr    = (kind >= 4);
    r.addr  = 10'(32'h0F0 + $urandom_range(31));
    r.data  = $urandom;
    r.be    = 4'($urandom_range(15));
    return r;
  endfunction

  task automatic test_reset();
    a_read = 1; b_write = 1;
    repeat (2) begin
      @(negedge clk);
      checks++; if (a_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_a_wait got %b exp 1", a_waitrequest); end
      checks++; if (b_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_b_wait got %b exp 1", b_waitrequest); end
      checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL rst_cs got %b exp 0", mem_chipselect); end
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write got %b exp 0", mem_write); end
      checks++; if ({a_readdatavalid, b_readdatavalid} !== 2'b00) begin errors++; $display("FAIL rst_rdv got %b exp 00", {a_readdatavalid, b_readdatavalid}); end
      checks++; if (wp_violation !== 1'b0) begin errors++; $display("FAIL rst_wp got %b exp 0", wp_violation); end
      tick();
    end
    reset = 0;
    drive_idle();
    m_owner = 0; m_hold = 0;
    @(negedge clk);
    checks++; if ({a_waitrequest, b_waitrequest} !== 2'b00) begin errors++; $display("FAIL idle_wait got %b exp 00", {a_waitrequest, b_waitrequest}); end
    checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL idle_cs got %b exp 0", mem_chipselect); end
    tick();
  endtask

  task automatic test_single_a();
    a_write = 1; a_address = 10'h005; a_writedata = 32'hDEADBEEF; a_byteenable = 4'hF;
    @(negedge clk);
    checks++; if (a_waitrequest !== 1'b0) begin errors++; $display("FAIL single_wr_wait got %b exp 0", a_waitrequest); end
    checks++; if ({mem_chipselect, mem_write} !== 2'b11) begin errors++; $display("FAIL single_wr_cmd got %b exp 11", {mem_chipselect, mem_write}); end
    checks++; if (mem_address !== 10'h005) begin errors++; $display("FAIL single_wr_addr got %h exp 005", mem_address); end
    ref_mem[10'h005] = 32'hDEADBEEF;
    tick();
    a_write = 0; a_read = 1;
    @(negedge clk);
    checks++; if (a_waitrequest !== 1'b0) begin errors++; $display("FAIL single_rd_wait got %b exp 0", a_waitrequest); end
    checks++; if (a_readdatavalid !== 1'b0) begin errors++; $display("FAIL single_rdv_early got %b exp 0", a_readdatavalid); end
    tick();
    drive_idle();
    @(negedge clk);
    checks++; if (a_readdatavalid !== 1'b1) begin errors++; $display("FAIL single_rdv got %b exp 1", a_readdatavalid); end
    checks++; if (a_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got %h exp deadbeef", a_readdata); end
    checks++; if (b_readdatavalid !== 1'b0) begin errors++; $display("FAIL single_b_rdv got %b exp 0", b_readdatavalid); end
    tick();
    @(negedge clk);
    checks++; if (a_readdatavalid !== 1'b0) begin errors++; $display("FAIL single_rdv_once got %b exp 0", a_readdatavalid); end
    tick();
  endtask

  task automatic test_byteenable();
    bit [31:0] exp;
    exp = WP_ON ? 32'h11223344 : 32'h1122CC44;
    a_write = 1; a_address = 10'h010; a_writedata = 32'h11223344; a_byteenable = 4'hF;
    tick();
    drive_idle();
    b_write = 1; b_address = 10'h010; b_writedata = 32'hAABBCCDD; b_byteenable = 4'b0010;
    @(negedge clk);
    checks++; if (b_waitrequest !== 1'b0) begin errors++; $display("FAIL be_b_wait got %b exp 0", b_waitrequest); end
    tick();
    drive_idle();
    a_read = 1; a_address = 10'h010;
    tick();
    drive_idle();
    @(negedge clk);
    checks++; if (a_readdatavalid !== 1'b1 || a_readdata !== exp) begin errors++; $display("FAIL be_merge got %b/%h exp 1/%h", a_readdatavalid, a_readdata, exp); end
    ref_mem[10'h010] = exp;
    tick();
  endtask

  task automatic test_contention();
    bit [9:0]  pa_addr, pb_addr;
    bit [31:0] prev_data;
    int        prev, w;
    apply_reset(2);
    pa_addr = 10'h005; pb_addr = 10'h010; prev = -1; prev_data = '0;
    for (int k = 0; k < 48; k++) begin
      a_read = 1; a_address = pa_addr;
      b_read = 1; b_address = pb_addr;
      w = (k / MAX_HOLD) % 2;
      @(negedge clk);
      checks++; if (a_waitrequest !== (w != 0)) begin errors++; $display("FAIL cont_a_wait k=%0d got %b exp %b", k, a_waitrequest, w != 0); end
      checks++; if (b_waitrequest !== (w != 1)) begin errors++; $display("FAIL cont_b_wait k=%0d got %b exp %b", k, b_waitrequest, w != 1); end
      checks++; if (a_readdatavalid !== (prev == 0) || b_readdatavalid !== (prev == 1)) begin
        errors++; $display("FAIL cont_rdv k=%0d got %b%b exp %b%b", k, a_readdatavalid, b_readdatavalid, prev == 0, prev == 1);
      end
      if (prev >= 0) begin
        checks++; if (a_readdata !== prev_data) begin errors++; $display("FAIL cont_rdata k=%0d got %h exp %h", k, a_readdata, prev_data); end
      end
      prev = w;
      prev_data = ref_mem[w == 0 ? pa_addr : pb_addr];
      if (w == 0) pa_addr = 10'($urandom); else pb_addr = 10'($urandom);
      tick();
    end
    drive_idle();
    @(negedge clk);
    checks++; if (b_readdatavalid !== 1'b1 || b_readdata !== prev_data) begin errors++; $display("FAIL cont_last got %b/%h exp 1/%h", b_readdatavalid, b_readdata, prev_data); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    drive_idle();
    a_read = 1; a_address = 10'h005;
    @(negedge clk);
    checks++; if (a_waitrequest !== 1'b0) begin errors++; $display("FAIL mid_grant got %b exp 0", a_waitrequest); end
    tick();
    reset = 1; b_read = 1; b_address = 10'h010;
    repeat (2) begin
      @(negedge clk);
      checks++; if ({a_readdatavalid, b_readdatavalid} !== 2'b00) begin errors++; $display("FAIL mid_rdv got %b exp 00", {a_readdatavalid, b_readdatavalid}); end
      checks++; if ({a_waitrequest, b_waitrequest} !== 2'b11) begin errors++; $display("FAIL mid_wait got %b exp 11", {a_waitrequest, b_waitrequest}); end
      checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL mid_cs got %b exp 0", mem_chipselect); end
      tick();
    end
    reset = 0;
    @(negedge clk);
    checks++; if ({a_waitrequest, b_waitrequest} !== 2'b01) begin errors++; $display("FAIL mid_first_grant got %b exp 01", {a_waitrequest, b_waitrequest}); end
    checks++; if (a_readdatavalid !== 1'b0) begin errors++; $display("FAIL mid_dropped got %b exp 0", a_readdatavalid); end
    tick();
    drive_idle();
    @(negedge clk);
    checks++; if (a_readdatavalid !== 1'b1 || a_readdata !== ref_mem[10'h005]) begin errors++; $display("FAIL mid_after got %b/%h exp 1/%h", a_readdatavalid, a_readdata, ref_mem[10'h005]); end
    tick();
  endtask

  task automatic test_rw_same();
    a_read = 1; a_write = 1; a_address = 10'h020; a_writedata = 32'h5; a_byteenable = 4'hF;
    @(negedge clk);
    checks++; if (a_waitrequest !== 1'b0 || mem_write !== 1'b1) begin errors++; $display("FAIL rw_cmd got %b%b exp 01", a_waitrequest, mem_write); end
    ref_mem[10'h020] = 32'h5;
    tick();
    drive_idle();
    a_read = 1; a_address = 10'h020;
    @(negedge clk);
    checks++; if (a_readdatavalid !== 1'b0) begin errors++; $display("FAIL rw_no_rdv got %b exp 0", a_readdatavalid); end
    tick();
    drive_idle();
    @(negedge clk);
    checks++; if (a_readdatavalid !== 1'b1 || a_readdata !== 32'h5) begin errors++; $display("FAIL rw_word got %b/%h exp 1/00000005", a_readdatavalid, a_readdata); end
    tick();
  endtask

  task automatic test_wp();
    bit [31:0] d;
    apply_reset(2);
    @(negedge clk);
    checks++; if (wp_violation !== 1'b0) begin errors++; $display("FAIL wp_clear got %b exp 0", wp_violation); end
    b_write = 1; b_address = 10'h080; b_writedata = 32'hFFFFFFFF; b_byteenable = 4'hF;
    @(negedge clk);
    checks++; if (b_waitrequest !== 1'b0) begin errors++; $display("FAIL wp_b_wait got %b exp 0", b_waitrequest); end
    checks++; if (mem_write !== !WP_ON) begin errors++; $display("FAIL wp_mem_write got %b exp %b", mem_write, !WP_ON); end
    if (!wp_blocks(1, 1'b1, 10'h080)) ref_mem[10'h080] = 32'hFFFFFFFF;
    tick();
    drive_idle();
    a_read = 1; a_address = 10'h080;
    @(negedge clk);
    checks++; if (wp_violation !== WP_ON) begin errors++; $display("FAIL wp_flag got %b exp %b", wp_violation, WP_ON); end
    tick();
    drive_idle();
    @(negedge clk);
    checks++; if (a_readdata !== ref_mem[10'h080]) begin errors++; $display("FAIL wp_word got %h exp %h", a_readdata, ref_mem[10'h080]); end
    checks++; if (wp_violation !== WP_ON) begin errors++; $display("FAIL wp_held got %b exp %b", wp_violation, WP_ON); end
    tick();
    d = $urandom;
    b_write = 1; b_address = 10'h100; b_writedata = d; b_byteenable = 4'hF;
    @(negedge clk);
    checks++; if ({mem_chipselect, mem_write} !== 2'b11) begin errors++; $display("FAIL wp_out_cmd got %b exp 11", {mem_chipselect, mem_write}); end
    ref_mem[10'h100] = d;
    tick();
    drive_idle();
    b_read = 1; b_address = 10'h100;
    tick();
    drive_idle();
    @(negedge clk);
    checks++; if (b_readdatavalid !== 1'b1 || b_readdata !== d) begin errors++; $display("FAIL wp_out_word got %b/%h exp 1/%h", b_readdatavalid, b_readdata, d); end
    tick();
  endtask

  task automatic test_random();
    req_t      pa, pb, r;
    int        w, exp_port;
    bit        blocked, exp_v, exp_wp, exp_cs, exp_mw;
    bit [31:0] exp_data;
    apply_reset(2);
    pa = '{default: 0}; pb = '{default: 0};
    exp_v = 0; exp_port = 0; exp_data = '0; exp_wp = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!pa.valid && $urandom_range(9) < 6) pa = new_req();
      if (!pb.valid && $urandom_range(9) < 6) pb = new_req();
      a_read = pa.valid & pa.rd; a_write = pa.valid & pa.wr; a_address = pa.addr;
      a_writedata = pa.data; a_byteenable = pa.be;
      b_read = pb.valid & pb.rd; b_write = pb.valid & pb.wr; b_address = pb.addr;
      b_writedata = pb.data; b_byteenable = pb.be;
      w = pick(pa.valid, pb.valid);
      r = (w == 1) ? pb : pa;
      blocked = (w >= 0) && wp_blocks(w, r.wr, r.addr);
      exp_cs  = (w >= 0) && !blocked;
      exp_mw  = (w >= 0) && r.wr && !blocked;
      @(negedge clk);
      checks++; if (a_waitrequest !== (pa.valid && w != 0)) begin errors++; $display("FAIL rnd_a_wait c=%0d got %b exp %b", cyc, a_waitrequest, pa.valid && w != 0); end
      checks++; if (b_waitrequest !== (pb.valid && w != 1)) begin errors++; $display("FAIL rnd_b_wait c=%0d got %b exp %b", cyc, b_waitrequest, pb.valid && w != 1); end
      checks++; if (mem_chipselect !== exp_cs || mem_write !== exp_mw) begin errors++; $display("FAIL rnd_cmd c=%0d got %b%b exp %b%b", cyc, mem_chipselect, mem_write, exp_cs, exp_mw); end
      checks++; if (a_readdatavalid !== (exp_v && exp_port == 0) || b_readdatavalid !== (exp_v && exp_port == 1)) begin
        errors++; $display("FAIL rnd_rdv c=%0d got %b%b exp %b%b", cyc, a_readdatavalid, b_readdatavalid, exp_v && exp_port == 0, exp_v && exp_port == 1);
      end
      if (exp_v) begin
        checks++; if ((exp_port == 0 ? a_readdata : b_readdata) !== exp_data) begin errors++; $display("FAIL rnd_rdata c=%0d got %h exp %h", cyc, exp_port == 0 ? a_readdata : b_readdata, exp_data); end
      end
      checks++; if (wp_violation !== exp_wp) begin errors++; $display("FAIL rnd_wp c=%0d got %b exp %b", cyc, wp_violation, exp_wp); end
      exp_v = 0;
      if (w >= 0) begin
        if (r.wr) begin
          if (!blocked) ref_mem[r.addr] = merge(ref_mem[r.addr], r.data, r.be);
        end else begin
          exp_v = 1; exp_port = w; exp_data = ref_mem[r.addr];
        end
        if (w == 0) pa.valid = 0; else pb.valid = 0;
      end
      exp_wp = exp_wp | blocked;
      note_grant(w);
      tick();
    end
    drive_idle();
    @(negedge clk);
    checks++; if (a_readdatavalid !== (exp_v && exp_port == 0) || b_readdatavalid !== (exp_v && exp_port == 1)) begin
      errors++; $display("FAIL rnd_drain got %b%b exp %b%b", a_readdatavalid, b_readdatavalid, exp_v && exp_port == 0, exp_v && exp_port == 1);
    end
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_single_a();
    test_byteenable();
    test_contention();
    test_reset_mid_read();
    test_rw_same();
    test_wp();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
